// File: rtl/univ_shreg_if.sv
// Control and data bundle for the universal shift register.
// The master drives operation controls; the slave (the register) returns its state.
interface univ_shreg_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdin;
  logic [WIDTH-1:0] pdout;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             word_done;

  modport master (
    output en, mode, sin_r, sin_l, pdin,
    input  pdout, sout, cnt, word_done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pdin,
    output pdout, sout, cnt, word_done
  );
endinterface

// File: rtl/univ_shreg.sv
// Universal shift register: shift/rotate in both directions, parallel load, clear.
// Counts shifts per word and pulses word_done when WIDTH shifts have completed.
module univ_shreg #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  univ_shreg_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(bus.mode);

  always_comb begin
    q_d      = q_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (bus.en) begin
      unique case (mode_sel)
        MODE_SHR: begin
          q_d      = {bus.sin_r, q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], bus.sin_l};
          sout_d   = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d   = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.pdin;
          cnt_d = '0;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Counter wraps on the WIDTH-th shift of a word and flags completion.
    if (shift_op) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.pdout     = q_q;
  assign bus.sout      = sout_q;
  assign bus.cnt       = cnt_q;
  assign bus.word_done = done_q;
endmodule

// File: tb/tb_univ_shreg.sv
// Bench for univ_shreg at WIDTH=4: directed scenarios plus random traffic,
// all checked against an arithmetic reference model.
module tb_univ_shreg;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  int m_q, m_s, m_c, m_d;

  univ_shreg_if #(.WIDTH(W)) bus ();
  univ_shreg #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int m, input int sr, input int sl, input int d);
    bit bump;
    bump = 0;
    if (r) begin
      m_q = 0; m_s = 0; m_c = 0; m_d = 0;
      return;
    end
    m_d = 0;
    if (!e) return;
    case (m)
      1: begin m_s = m_q % 2; m_q = (m_q / 2) + sr * (1 << (W-1)); bump = 1; end
      2: begin m_s = m_q / (1 << (W-1)); m_q = (m_q * 2 + sl) % (1 << W); bump = 1; end
      3: begin m_s = m_q % 2; m_q = (m_q / 2) + m_s * (1 << (W-1)); bump = 1; end
      4: begin m_s = m_q / (1 << (W-1)); m_q = (m_q * 2 + m_s) % (1 << W); bump = 1; end
      5: begin m_q = d & MASK; m_c = 0; end
      6: begin m_q = 0; m_c = 0; end
      default: ;
    endcase
    if (bump) begin
      m_c = m_c + 1;
      if (m_c == W) begin
        m_c = 0;
        m_d = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input int m, input int sr, input int sl, input int d);
    rst       = r;
    bus.en    = e;
    bus.mode  = 3'(m);
    bus.sin_r = sr[0];
    bus.sin_l = sl[0];
    bus.pdin  = 4'(d);
    @(posedge clk);
    #1;
    model_step(r, e, m, sr, sl, d);
    check_eq("pdout", 64'(bus.pdout), 64'(m_q));
    check_eq("sout", 64'(bus.sout), 64'(m_s));
    check_eq("cnt", 64'(bus.cnt), 64'(m_c));
    check_eq("word_done", 64'(bus.word_done), 64'(m_d));
  endtask

  initial begin
    int pulses;
    int srv[4];
    int sout_seq[4];

    rst = 1'b1; bus.en = 1'b0; bus.mode = 3'b0;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.pdin = '0;
    m_q = 0; m_s = 0; m_c = 0; m_d = 0;

    // shift right: sin_r 1,0,1,1 -> 1101 with one done pulse
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rst_pdout", 64'(bus.pdout), 64'd0);
    check_eq("rst_cnt", 64'(bus.cnt), 64'd0);
    srv = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, srv[i], 0, 0);
      check_eq("shr_done", 64'(bus.word_done), (i == 3) ? 64'd1 : 64'd0);
    end
    check_eq("shr_pdout", 64'(bus.pdout), 64'hD);
    check_eq("shr_cnt", 64'(bus.cnt), 64'd0);
    cyc(0, 1, 0, 0, 0, 0);
    check_eq("shr_done_drop", 64'(bus.word_done), 64'd0);

    // load and shift left
    cyc(0, 1, 5, 0, 0, 4'b1001);
    check_eq("ld_cnt", 64'(bus.cnt), 64'd0);
    cyc(0, 1, 2, 0, 0, 0);
    check_eq("shl_sout1", 64'(bus.sout), 64'd1);
    cyc(0, 1, 2, 0, 0, 0);
    check_eq("shl_sout2", 64'(bus.sout), 64'd0);
    check_eq("shl_pdout", 64'(bus.pdout), 64'h4);
    check_eq("shl_cnt", 64'(bus.cnt), 64'd2);

    // hold: en=0 with a shift mode selected
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
      check_eq("hold_pdout", 64'(bus.pdout), 64'h4);
      check_eq("hold_cnt", 64'(bus.cnt), 64'd2);
      check_eq("hold_done", 64'(bus.word_done), 64'd0);
    end
    cyc(0, 1, 7, 1, 1, 0);
    check_eq("rsvd_pdout", 64'(bus.pdout), 64'h4);

    // rotate right four times returns the word
    cyc(0, 1, 5, 0, 0, 4'b0011);
    sout_seq = '{1, 1, 0, 0};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 3, 0, 0, 0);
      check_eq("ror_sout", 64'(bus.sout), 64'(sout_seq[i]));
      pulses += int'(bus.word_done);
    end
    check_eq("ror_pdout", 64'(bus.pdout), 64'h3);
    check_eq("ror_pulses", 64'(pulses), 64'd1);

    // reset mid-word abandons the count
    cyc(0, 1, 2, 0, 1, 0);
    cyc(0, 1, 2, 0, 1, 0);
    cyc(0, 1, 2, 0, 1, 0);
    cyc(1, 1, 2, 0, 1, 0);
    check_eq("rstmid_pdout", 64'(bus.pdout), 64'd0);
    check_eq("rstmid_sout", 64'(bus.sout), 64'd0);
    check_eq("rstmid_cnt", 64'(bus.cnt), 64'd0);
    pulses = 0;
    cyc(0, 1, 2, 0, 1, 0);
    pulses += int'(bus.word_done);
    check_eq("post_rst_cnt", 64'(bus.cnt), 64'd1);
    cyc(0, 1, 0, 0, 0, 0);
    pulses += int'(bus.word_done);
    check_eq("rstmid_pulses", 64'(pulses), 64'd0);

    // interrupted word: load restarts the count
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 5, 0, 0, 4'b0110);
    check_eq("intr_cnt", 64'(bus.cnt), 64'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, (i % 2) ? 2 : 1, i % 2, 1, 0);
      pulses += int'(bus.word_done);
    end
    cyc(0, 1, 0, 0, 0, 0);
    pulses += int'(bus.word_done);
    check_eq("intr_pulses", 64'(pulses), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(99) < 2) ? 1 : 0,
          ($urandom_range(99) < 80) ? 1 : 0,
          int'($urandom_range(7)),
          int'($urandom_range(1)),
          int'($urandom_range(1)),
          int'($urandom_range(MASK)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
